// File: rtl/stage_sequencer.sv
// Instruction stage sequencer: emits one-cycle IF/ID/ALU/MEM/RB_BR strobes and
// reacts to interrupt, halt and memory stall. Optional: STAGE_SEQ_SINGLE_STEP_EN.
module stage_sequencer #(
  parameter int STAGE_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             interrupt,
  input  logic             int_ack,
  input  logic [2:0]       branch_opcode,
  input  logic             mem_busy,
`ifdef STAGE_SEQ_SINGLE_STEP_EN
  input  logic             step,
  output logic [3:0]       stage,
`else
  output logic [2:0]       stage,
`endif
  output logic             IF_clk,
  output logic             ID_clk,
  output logic             ALU_clk,
  output logic             MEM_clk,
  output logic             RB_BR_clk,
  output logic             running,
  output logic             halted,
  output logic             int_pending,
  output logic [CNT_W-1:0] retire_count
);

`ifdef STAGE_SEQ_SINGLE_STEP_EN
  localparam int SW = 4;
  typedef enum logic [SW-1:0] {
    S_IDLE = 4'd0, S_IF = 4'd1, S_ID = 4'd2, S_ALU = 4'd3, S_MEM = 4'd4,
    S_RB = 4'd5, S_PAUSE = 4'd6, S_HALT = 4'd7, S_INT = 4'd8
  } state_t;
`else
  localparam int SW = 3;
  typedef enum logic [SW-1:0] {
    S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_ALU = 3'd3, S_MEM = 3'd4,
    S_RB = 3'd5, S_INT = 3'd6, S_HALT = 3'd7
  } state_t;
`endif

  state_t           state, state_nx;
  logic [3:0]       sub_cnt;
  logic [4:0]       stb_q, stb_d;  // [0]=IF .. [4]=RB_BR
  logic [CNT_W-1:0] retire_q;
  logic             last, in_stage, retire_inc;
  logic             step_rise;

  assign last     = (sub_cnt == 4'(STAGE_CYCLES - 1));
  assign in_stage = (state == S_IF) || (state == S_ID) || (state == S_ALU) ||
                    (state == S_MEM) || (state == S_RB);

`ifdef STAGE_SEQ_SINGLE_STEP_EN
  logic step_q;
  assign step_rise = step & ~step_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
`else
  assign step_rise = 1'b0;
`endif

  // Retirement: normal RB exit, HALT entry, and MTC completion on INT_WAIT exit.
  assign retire_inc = ((state == S_RB) && (state_nx != S_RB)) ||
                      ((state != S_HALT) && (state_nx == S_HALT)) ||
                      ((state == S_INT) && (state_nx != S_INT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sub_cnt  <= 4'd0;
      stb_q    <= 5'd0;
      retire_q <= '0;
    end else begin
      state <= state_nx;
      stb_q <= stb_d;
      if (state_nx != state || !in_stage) sub_cnt <= 4'd0;
      else if (!last)                      sub_cnt <= sub_cnt + 4'd1;
      if (retire_inc) retire_q <= retire_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_IF;
      S_IF:    if (last)  state_nx = S_ID;
      // interrupt wins over any branch decode in ID
      S_ID:    if (last)  state_nx = interrupt ? S_INT : S_ALU;
      S_ALU:   if (last)  state_nx = (branch_opcode == 3'b000) ? S_HALT : S_MEM;
      S_MEM:   if (last && !mem_busy) state_nx = S_RB;
`ifdef STAGE_SEQ_SINGLE_STEP_EN
      S_RB:    if (last)    state_nx = S_PAUSE;
      S_INT:   if (int_ack) state_nx = S_PAUSE;
      S_PAUSE: if (step_rise) state_nx = S_IF;
`else
      S_RB:    if (last)    state_nx = S_IF;
      S_INT:   if (int_ack) state_nx = S_IF;
`endif
      S_HALT:  if (start) state_nx = S_IF;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    stb_d = 5'd0;
    if (state_nx != state) begin
      case (state_nx)
        S_IF:    stb_d = 5'b00001;
        S_ID:    stb_d = 5'b00010;
        S_ALU:   stb_d = 5'b00100;
        S_MEM:   stb_d = 5'b01000;
        S_RB:    stb_d = 5'b10000;
        default: stb_d = 5'd0;
      endcase
    end
    running     = in_stage;
    halted      = (state == S_HALT);
    int_pending = (state == S_INT);
  end

  assign IF_clk       = stb_q[0];
  assign ID_clk       = stb_q[1];
  assign ALU_clk      = stb_q[2];
  assign MEM_clk      = stb_q[3];
  assign RB_BR_clk    = stb_q[4];
  assign stage        = state;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed table-driven bench for stage_sequencer (STAGE_CYCLES=2, CNT_W=3 so
// the retire counter wrap is reachable).
module tb_stage_sequencer;
  localparam int CW = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, interrupt = 1'b0, int_ack = 1'b0, mem_busy = 1'b0;
  logic [2:0] branch_opcode = 3'b011;
  logic IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk;
  logic running, halted, int_pending;
  logic [CW-1:0] retire_count;
`ifdef STAGE_SEQ_SINGLE_STEP_EN
  logic step = 1'b0;
  logic [3:0] stage;
`else
  logic [2:0] stage;
`endif

  stage_sequencer #(.STAGE_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .interrupt(interrupt),
    .int_ack(int_ack), .branch_opcode(branch_opcode), .mem_busy(mem_busy),
`ifdef STAGE_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .IF_clk(IF_clk), .ID_clk(ID_clk), .ALU_clk(ALU_clk), .MEM_clk(MEM_clk),
    .RB_BR_clk(RB_BR_clk), .running(running), .halted(halted),
    .int_pending(int_pending), .stage(stage), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, in, ac, bz;
    logic [2:0] bop;
    logic [4:0] stb;   // {IF,ID,ALU,MEM,RB}
    logic [2:0] stg;
    logic [2:0] rc;
  } vec_t;

  localparam logic [4:0] F = 5'b10000, D = 5'b01000, A = 5'b00100,
                         M = 5'b00010, R = 5'b00001, N = 5'b00000;

  vec_t tv[$];
  int checks = 0, errors = 0;

  task automatic v(input logic st, in, ac, bz, input logic [2:0] bop,
                   input logic [4:0] stb, input logic [2:0] stg, input logic [2:0] rc);
    vec_t e;
    e.st = st; e.in = in; e.ac = ac; e.bz = bz; e.bop = bop;
    e.stb = stb; e.stg = stg; e.rc = rc;
    tv.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk};
  endfunction

  initial begin
    // normal instructions; start high in ID is ignored
    v(1,0,0,0,3,F,1,0); v(0,0,0,0,3,N,1,0); v(1,0,0,0,3,D,2,0); v(1,0,0,0,3,N,2,0);
    v(0,0,0,0,3,A,3,0); v(0,0,0,0,3,N,3,0); v(0,0,0,0,3,M,4,0); v(0,0,0,0,3,N,4,0);
    v(0,0,0,0,3,R,5,0); v(0,0,0,0,3,N,5,0); v(0,0,0,0,3,F,1,1); v(0,0,0,0,3,N,1,1);
    v(0,0,0,0,3,D,2,1); v(0,0,0,0,3,N,2,1); v(0,0,0,0,3,A,3,1); v(0,0,0,0,3,N,3,1);
    v(0,0,0,0,3,M,4,1); v(0,0,0,0,3,N,4,1); v(0,0,0,0,3,R,5,1); v(0,0,0,0,3,N,5,1);
    v(0,0,0,0,3,F,1,2); v(0,0,0,0,3,N,1,2); v(0,0,0,0,3,D,2,2); v(0,0,0,0,3,N,2,2);
    // halt in ALU, then restart
    v(0,0,0,0,3,A,3,2); v(0,0,0,0,3,N,3,2); v(0,0,0,0,0,N,7,3); v(0,0,0,0,3,N,7,3);
    v(1,0,0,0,3,F,1,3); v(0,0,0,0,3,N,1,3); v(0,0,0,0,3,D,2,3);
    // interrupt: ignored in ID first cycle, taken in last; ack 5 cycles later
    v(0,1,0,0,3,N,2,3); v(0,1,0,0,3,N,6,3); v(0,0,0,0,3,N,6,3); v(0,0,0,0,3,N,6,3);
    v(0,0,0,0,3,N,6,3); v(0,0,0,0,3,N,6,3); v(0,0,1,0,3,F,1,4); v(0,0,0,0,3,N,1,4);
    // opcode 000 outside the ALU last cycle must not halt
    v(0,0,0,0,3,D,2,4); v(0,0,0,0,0,N,2,4); v(0,0,0,0,0,A,3,4); v(0,0,0,0,0,N,3,4);
    v(0,0,0,0,3,M,4,4);
    // mem_busy for 7 cycles from MEM entry
    v(0,0,0,1,3,N,4,4); v(0,0,0,1,3,N,4,4); v(0,0,0,1,3,N,4,4); v(0,0,0,1,3,N,4,4);
    v(0,0,0,1,3,N,4,4); v(0,0,0,1,3,N,4,4); v(0,0,0,1,3,N,4,4);
    v(0,0,0,0,3,R,5,4); v(0,0,0,0,3,N,5,4); v(0,0,0,0,3,F,1,5); v(0,0,0,0,3,N,1,5);
    // int_ack already high on INT_WAIT entry: one cycle there
    v(0,0,0,0,3,D,2,5); v(0,0,0,0,3,N,2,5); v(0,1,1,0,3,N,6,5); v(0,0,1,0,3,F,1,6);
    // halt with start already high
    v(0,0,0,0,3,N,1,6); v(0,0,0,0,3,D,2,6); v(0,0,0,0,3,N,2,6); v(0,0,0,0,3,A,3,6);
    v(0,0,0,0,3,N,3,6); v(1,0,0,0,0,N,7,7); v(1,0,0,0,3,F,1,7);
    // retire counter wraps 7 -> 0
    v(0,0,0,0,3,N,1,7); v(0,0,0,0,3,D,2,7); v(0,0,0,0,3,N,2,7); v(0,0,0,0,3,A,3,7);
    v(0,0,0,0,3,N,3,7); v(0,0,0,0,3,M,4,7); v(0,0,0,0,3,N,4,7); v(0,0,0,0,3,R,5,7);
    v(0,0,0,0,3,N,5,7); v(0,0,0,0,3,F,1,0);

    #12;
    chk("reset_strobes", 32'(strobes()), 0);
    chk("reset_stage", 32'(stage), 0);
    chk("reset_flags", {29'd0, running, halted, int_pending}, 0);
    chk("reset_retire", 32'(retire_count), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      logic [2:0] fl;
      start = tv[i].st; interrupt = tv[i].in; int_ack = tv[i].ac;
      mem_busy = tv[i].bz; branch_opcode = tv[i].bop;
      @(posedge clk); #1;
      fl = {(tv[i].stg >= 3'd1 && tv[i].stg <= 3'd5), tv[i].stg == 3'd7, tv[i].stg == 3'd6};
      chk($sformatf("row%0d_strobes", i), 32'(strobes()), 32'(tv[i].stb));
      chk($sformatf("row%0d_stage", i), 32'(stage), 32'(tv[i].stg));
      chk($sformatf("row%0d_retire", i), 32'(retire_count), 32'(tv[i].rc));
      chk($sformatf("row%0d_flags", i), {29'd0, running, halted, int_pending}, 32'(fl));
    end

    // asynchronous reset while ALU_clk is high
    start = 1'b0; interrupt = 1'b0; int_ack = 1'b0; mem_busy = 1'b0; branch_opcode = 3'b011;
    repeat (4) @(posedge clk);
    #1 chk("mid_alu_strobe", 32'(strobes()), 32'(A));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_strobes", 32'(strobes()), 0);
    chk("async_rst_stage", 32'(stage), 0);
    chk("async_rst_flags", {29'd0, running, halted, int_pending}, 0);
    chk("async_rst_retire", 32'(retire_count), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_idle%0d_strobes", i), 32'(strobes()), 0);
      chk($sformatf("post_rst_idle%0d_stage", i), 32'(stage), 0);
    end
    start = 1'b1;
    @(posedge clk); #1;
    chk("restart_if_strobe", 32'(strobes()), 32'(F));
    chk("restart_stage", 32'(stage), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
